// File: rtl/rs15_pkg.sv
// Shared definitions for the RS(15,9) code over GF(16), primitive polynomial
// x^4 + x + 1.
// Contents: symbol and code sizes, generator coefficients g0..g5, the FSM
// state type, and a GF(16) multiply that uses the polynomial basis.
// The decoder uses the same basis and the same multiply.
package rs15_pkg;

  localparam int SYM_W   = 4;
  localparam int N       = 15;
  localparam int K       = 9;
  localparam int NUM_PAR = N - K;

  // alpha^4 = alpha + 1. These are the low bits to fold back after an overflow.
  localparam logic [SYM_W-1:0] PRIM_POLY_LOW = 4'h3;

  // g(x) = prod_{i=1..6}(x + alpha^i). g6 = 1 is implicit.
  localparam logic [SYM_W-1:0] G0 = 4'hC;
  localparam logic [SYM_W-1:0] G1 = 4'hA;
  localparam logic [SYM_W-1:0] G2 = 4'hC;
  localparam logic [SYM_W-1:0] G3 = 4'h3;
  localparam logic [SYM_W-1:0] G4 = 4'h9;
  localparam logic [SYM_W-1:0] G5 = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_DONE
  } enc_state_t;

  // Shift-and-add multiply. When one operand is constant it reduces to XORs.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYM_W-1] ? ({sh[SYM_W-2:0], 1'b0} ^ PRIM_POLY_LOW)
                       : {sh[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// Multiplies a GF(16) symbol by the constant COEF. The result is pure XOR logic.
// Ports:
//   sym_i  [3:0]  input symbol
//   prod_o [3:0]  sym_i * COEF in GF(16)
module gf16_const_mul
  import rs15_pkg::*;
#(
  parameter logic [SYM_W-1:0] COEF = 4'h1
) (
  input  logic [SYM_W-1:0] sym_i,
  output logic [SYM_W-1:0] prod_o
);

  assign prod_o = gf_mul(sym_i, COEF);

endmodule

// File: rtl/rs15_9_encoder_seq.sv
// Sequential systematic RS(15,9) encoder. It feeds one message symbol per
// clock into a 6-stage GF(16) LFSR, processing the highest symbol first.
// The codeword is {message, p5..p0}.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   messageIn      9 symbols, m_k = messageIn[4k+:4]
//   messageValid / messageReady    input handshake
//   codewordOut    15 symbols, c_i = codewordOut[4i+:4]
//   codewordValid / codewordReady  output handshake
//   encoderBusy    high while encoding or holding a finished codeword
// NUM_MSG_SYM and NUM_PAR_SYM are fixed at 9 and 6. They are exposed only to
// make the widths readable. No other values are legal.
module rs15_9_encoder_seq
  import rs15_pkg::*;
#(
  parameter int NUM_MSG_SYM = 9,
  parameter int NUM_PAR_SYM = 6
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_MSG_SYM*SYM_W-1:0]              messageIn,
  input  logic                                      messageValid,
  output logic                                      messageReady,
  output logic [(NUM_MSG_SYM+NUM_PAR_SYM)*SYM_W-1:0] codewordOut,
  output logic                                      codewordValid,
  input  logic                                      codewordReady,
  output logic                                      encoderBusy
);

  localparam int CNT_W = $clog2(NUM_MSG_SYM);

  localparam logic [NUM_PAR_SYM-1:0][SYM_W-1:0] GEN_COEF = {G5, G4, G3, G2, G1, G0};

  enc_state_t                                  state_q;
  logic [NUM_MSG_SYM*SYM_W-1:0]                msg_q;
  logic [NUM_PAR_SYM-1:0][SYM_W-1:0]           par_q;
  logic [NUM_PAR_SYM-1:0][SYM_W-1:0]           par_d;
  logic [CNT_W-1:0]                            cnt_q;
  logic [(NUM_MSG_SYM+NUM_PAR_SYM)*SYM_W-1:0]  cw_q;
  logic                                        ready_q;
  logic                                        valid_q;
  logic                                        busy_q;

  logic [SYM_W-1:0]                    cur_sym;
  logic [SYM_W-1:0]                    fb;
  logic [NUM_PAR_SYM-1:0][SYM_W-1:0]   gprod;

  assign cur_sym = msg_q[cnt_q*SYM_W +: SYM_W];
  assign fb      = cur_sym ^ par_q[NUM_PAR_SYM-1];

  for (genvar i = 0; i < NUM_PAR_SYM; i++) begin : g_fb_mul
    gf16_const_mul #(.COEF(GEN_COEF[i])) u_mul (
      .sym_i  (fb),
      .prod_o (gprod[i])
    );
  end

  // One LFSR step: shift the parity up by one stage and add g_i * fb.
  always_comb begin
    // NOTE: give every combinational output a default first, so no path
    // through the block can infer a latch.
    par_d    = '0;
    par_d[0] = gprod[0];
    for (int i = 1; i < NUM_PAR_SYM; i++) begin
      par_d[i] = par_q[i-1] ^ gprod[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the values present before the edge.
    if (reset) begin
      state_q <= ST_IDLE;
      par_q   <= '0;
      cnt_q   <= '0;
      cw_q    <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      // NOTE: msg_q is a pure data register. It is always loaded before it is
      // read, so it has no reset.
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (messageValid && ready_q) begin
            msg_q   <= messageIn;
            par_q   <= '0;
            cnt_q   <= CNT_W'(NUM_MSG_SYM - 1);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          par_q <= par_d;
          if (cnt_q == '0) begin
            // The last symbol is in, so par_d is the final parity.
            cw_q    <= {msg_q, par_d};
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (codewordReady) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign messageReady  = ready_q;
  assign codewordValid = valid_q;
  assign encoderBusy   = busy_q;
  assign codewordOut   = cw_q;

endmodule

// File: tb/tb_rs15_9_encoder_seq.sv
// Testbench for rs15_9_encoder_seq.
// The reference model builds GF(16) from log/antilog tables and derives g(x)
// from its roots. It encodes by polynomial long division. Handshake timing
// follows the latency and backpressure rules. Directed vectors pin the model
// to hand-computed codewords.
module tb_rs15_9_encoder_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] messageIn;
  logic        messageValid;
  logic        messageReady;
  logic [59:0] codewordOut;
  logic        codewordValid;
  logic        codewordReady;
  logic        encoderBusy;

  always #5 clk = ~clk;

  rs15_9_encoder_seq dut (
    .clk           (clk),
    .reset         (reset),
    .messageIn     (messageIn),
    .messageValid  (messageValid),
    .messageReady  (messageReady),
    .codewordOut   (codewordOut),
    .codewordValid (codewordValid),
    .codewordReady (codewordReady),
    .encoderBusy   (encoderBusy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [59:0] act, input logic [59:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // ---------------- GF(16) reference arithmetic ----------------
  logic [3:0] gexp[15];
  int         glog[16];
  logic [3:0] gen[7];

  function automatic logic [3:0] tb_mul(input logic [3:0] a, input logic [3:0] b);
    if (a == 0 || b == 0) return 4'h0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  task automatic build_field();
    logic [4:0] v;
    logic [3:0] nxt[7];
    v = 5'h1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v[3:0];
      glog[v[3:0]] = i;
      v = v << 1;
      if (v[4]) v = v ^ 5'h13;
    end
    // Build g(x) = prod (x + alpha^i) for i = 1..6. gen[j] is the coefficient of x^j.
    for (int j = 0; j < 7; j++) gen[j] = 4'h0;
    gen[0] = 4'h1;
    for (int i = 1; i <= 6; i++) begin
      for (int j = 0; j < 7; j++)
        nxt[j] = ((j > 0) ? gen[j-1] : 4'h0) ^ tb_mul(gen[j], gexp[i]);
      for (int j = 0; j < 7; j++) gen[j] = nxt[j];
    end
  endtask

  function automatic logic [59:0] ref_encode(input logic [35:0] m);
    logic [3:0]  r[15];
    logic [3:0]  q;
    logic [59:0] cw;
    for (int i = 0; i < 15; i++) r[i] = 4'h0;
    for (int k = 0; k < 9; k++) r[k+6] = m[4*k +: 4];
    for (int i = 14; i >= 6; i--) begin
      q = r[i];
      for (int j = 0; j < 7; j++) r[i-6+j] = r[i-6+j] ^ tb_mul(q, gen[j]);
    end
    cw[59:24] = m;
    for (int i = 0; i < 6; i++) cw[4*i +: 4] = r[i];
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [59:0] cw, input int j);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 15; i++) s = s ^ tb_mul(cw[4*i +: 4], gexp[(i*j) % 15]);
    return s;
  endfunction

  // ---------------- transaction/timing model ----------------
  logic        exp_ready = 1'b1;
  logic        exp_valid = 1'b0;
  logic [59:0] exp_cw    = '0;
  logic [59:0] pend_cw   = '0;
  int          enc_left  = 0;
  bit          cw_known  = 1'b1;  // codewordOut is defined after reset and while valid

  always @(posedge clk) begin
    if (reset) begin
      exp_ready = 1'b1;
      exp_valid = 1'b0;
      exp_cw    = '0;
      enc_left  = 0;
      cw_known  = 1'b1;
    end else if (exp_valid) begin
      if (codewordReady) begin
        exp_valid = 1'b0;
        exp_ready = 1'b1;
      end
    end else if (enc_left > 0) begin
      enc_left--;
      if (enc_left == 0) begin
        exp_valid = 1'b1;
        exp_cw    = pend_cw;
        cw_known  = 1'b1;
      end
    end else if (exp_ready && messageValid) begin
      exp_ready = 1'b0;
      enc_left  = 9;
      pend_cw   = ref_encode(messageIn);
      cw_known  = 1'b0;
    end
  end

  // The single per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("messageReady", messageReady, exp_ready);
      check("codewordValid", codewordValid, exp_valid);
      check("encoderBusy", encoderBusy, (enc_left > 0) || exp_valid);
      if (cw_known || exp_valid) check("codewordOut", codewordOut, exp_cw);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [35:0] m, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    messageIn    = m;
    messageValid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (messageReady) begin
        @(posedge clk);
        #2;
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    messageValid = 1'b0;
    if (!done) timeout_fail("send");
  endtask

  task automatic wait_cw(output logic [59:0] cw, output int v_cyc);
    bit done;
    done  = 1'b0;
    cw    = '0;
    v_cyc = -1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (codewordValid) begin
        cw    = codewordOut;
        v_cyc = cyc;
        done  = 1'b1;
      end
    end
    if (!done) timeout_fail("wait_cw");
  endtask

  // One full transaction with codewordReady high. Handshake completes on the next edge.
  task automatic encode_one(input string name, input logic [35:0] m, input logic [59:0] exp);
    int          acc;
    int          vc;
    logic [59:0] cw;
    send(m, acc);
    wait_cw(cw, vc);
    check({name, "_cw"}, cw, exp);
    check({name, "_latency"}, 60'(vc - acc), 60'd9);
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          acc;
    int          vc;
    logic [59:0] cw;
    logic [35:0] m;

    build_field();
    reset         = 1'b1;
    messageIn     = '0;
    messageValid  = 1'b0;
    codewordReady = 1'b1;

    // Pin the model to the hand-derived codewords (g(x) and alpha*g(x)).
    check("model_g", ref_encode(36'h1), 60'h000000001793CAC);
    check("model_ag", ref_encode(36'h2), 60'h000000002E16B7B);

    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", messageReady, 1'b1);
    check("rst_valid", codewordValid, 1'b0);
    check("rst_busy", encoderBusy, 1'b0);
    check("rst_cw", codewordOut, 60'h0);
    chk_en = 1'b1;

    // Directed vectors.
    encode_one("zero", 36'h0, 60'h0);
    @(negedge clk);
    check("zero_valid_one_cycle", codewordValid, 1'b0);
    encode_one("m1", 36'h1, 60'h000000001793CAC);
    encode_one("m2", 36'h2, 60'h000000002E16B7B);

    // Backpressure: DONE must hold while new messages are ignored.
    codewordReady = 1'b0;
    send(36'h123456789, acc);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      messageValid = 1'b1;
      messageIn    = {4'(i), 32'hA5A5_0000 + 32'(i)};
    end
    @(negedge clk);
    check("bp_cw", codewordOut, ref_encode(36'h123456789));
    check("bp_ready", messageReady, 1'b0);
    messageValid  = 1'b0;
    codewordReady = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("bp_release_valid", codewordValid, 1'b0);
    check("bp_release_ready", messageReady, 1'b1);

    // Reset while the counter is at 4, which is four edges after the accept.
    send(36'hFEDCBA987, acc);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", codewordValid, 1'b0);
    check("abort_ready", messageReady, 1'b1);
    check("abort_cw", codewordOut, 60'h0);
    encode_one("after_abort", 36'h1, 60'h000000001793CAC);

    // Random messages: the result must match the model and have zero syndromes.
    for (int n = 0; n < 8; n++) begin
      m = {4'($urandom_range(15, 0)), 32'($urandom)};
      send(m, acc);
      wait_cw(cw, vc);
      check("rand_cw", cw, ref_encode(m));
      for (int j = 1; j <= 6; j++) check("rand_syndrome", 60'(syndrome(cw, j)), 60'h0);
      @(posedge clk);
      #2;
    end

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
